pic_interrupt_sequencer: RTL and testbench
==========================================

# pic_interrupt_sequencer

Control/sequencing block of the 8259A PIC. It owns the interrupt request and in-service state and runs the two-pulse INTA acknowledge sequence. It samples raw IR lines in edge or level mode, applies the IMR, and resolves fixed priority with nesting. It drives INT, produces the 8086-mode vector on the second INTA strobe, and retires in-service levels on EOI or automatic EOI. It sits between the IR pins, the command-word registers and the data bus buffer.

## Interface
- No parameters; 8 IR lines, fixed.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- IR0_to_IR7  in  8  raw interrupt requests, bit i = IRi
- ICW1  in  8  bit 3 = LTIM (1 level, 0 edge)
- ICW2  in  8  bits 7:3 = vector base T7..T3
- ICW4  in  8  bit 1 = AEOI
- OCW1  in  8  interrupt mask, 1 = masked
- intaStrobe  in  1  one-cycle pulse per INTA bus cycle
- eoiStrobe  in  1  one-cycle non-specific EOI command
- INT  out  1  interrupt request to CPU, registered
- vectorOut  out  8  vector for data bus, held until next second-INTA
- vectorValid  out  1  one-cycle pulse with a new vectorOut
- IRR  out  8  interrupt request register
- ISR  out  8  in-service register

## Operation
- Priority is fixed: IR0 highest, IR7 lowest. hiISR = lowest set index of ISR, or 8 if ISR = 0.
- eligible = IRR & ~OCW1, restricted to indices < hiISR. Only strictly higher priority nests.
- IRR update, every cycle. irPrev is a register of the previous IR0_to_IR7 and resets to 0.
  - Edge mode: IRR[i] set when IR[i] & ~irPrev[i]. Held until acknowledged.
  - Level mode: IRR[i] = IR[i] each cycle. Cleared on acknowledge if IR[i] is still high.
  - Acknowledge clear has priority over set in the same cycle.
- FSM states: IDLE, PEND, ACK2.
  - IDLE: INT=0. When eligible != 0 → PEND. intaStrobe is ignored.
  - PEND: INT=1. INT holds even if eligible drops (mask change, level removal).
  - PEND, on intaStrobe: level = index of highest eligible bit.
    - If eligible = 0, the cycle is spurious: level=7, ISR/IRR unchanged.
    - Otherwise set ISR[level] and clear IRR[level].
    - INT=0. Go to ACK2.
  - ACK2, on intaStrobe: vectorOut = {ICW2[7:3], level}, vectorValid=1 for one cycle.
    - If AEOI=1 and the cycle was not spurious, clear ISR[level].
    - Go to IDLE.
- eoiStrobe clears ISR[hiISR], evaluated on pre-update ISR. It is a no-op when ISR = 0. It is accepted in any state.
- Same-cycle EOI and first-INTA: EOI clears the old highest bit, then the new level bit is set.
- Mask, ICW and LTIM changes take effect in the same cycle. They do not alter a frozen level.

## Timing
- Reset values: INT=0, vectorOut=0x00, vectorValid=0, IRR=0x00, ISR=0x00, FSM=IDLE, irPrev=0x00.
- Reset is asynchronous and can abort mid-sequence. Outputs clear immediately and no pending vectorValid is emitted.
- Cycle k: IR rises and is seen at the edge; IRR shows it after edge k.
- Edge k+1: FSM enters PEND and INT=1, giving 2-clock request-to-INT latency.
- First intaStrobe at edge m: INT=0, ISR/IRR updated after edge m.
- Second intaStrobe at edge n: vectorOut and vectorValid are valid after edge n for one cycle.
- Earliest re-assertion: INT returns 2 edges after the second strobe (ACK2 → IDLE → PEND).
- IR held high at reset release counts as an edge on the first clock.

## Test plan
- Basic ack, edge mode:
  - Stimulus: ICW1=0x00, ICW2=0x40, OCW1=0x00, IR3 rises.
  - Response: IRR=0x08 after 1 edge, INT=1 after 2 edges.
  - Two strobes → ISR=0x08, IRR=0x00, vectorOut=0x43 with a single-cycle vectorValid.
- Nesting and EOI:
  - Stimulus: ISR=0x20 (IR5 in service), then IR6 and IR2 rise together.
  - Response: ack yields 0x42 and ISR=0x24. IR6 never raises INT.
  - EOI → ISR=0x20. Second EOI → ISR=0x00, then INT rises for IR6 (0x46).
- Masking:
  - Stimulus: OCW1=0x08, IR3 rises.
  - Response: IRR=0x08, INT stays 0 for 20 cycles. Write OCW1=0x00 → INT=1 one edge later.
- Spurious, level mode:
  - Stimulus: ICW1=0x08, IR4 high → INT=1, then IR4 drops before the first strobe.
  - Response: two strobes give vectorOut=0x47 with ISR=0x00 unchanged.
- AEOI:
  - Stimulus: ICW4=0x02, IR1 edge, full ack.
  - Response: ISR=0x02 between strobes and 0x00 after the second. vectorOut=0x41.
- Reset mid-sequence:
  - Stimulus: assert reset in ACK2.
  - Response: all outputs 0 asynchronously, FSM=IDLE. A later strobe produces no vectorValid.

Source files
------------

// File: rtl/pic_interrupt_sequencer.sv
// 8259A control/sequencing core: IRR/ISR ownership, fixed-priority nesting,
// and the two-pulse INTA acknowledge that yields the 8086-mode vector.
module pic_interrupt_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] IR0_to_IR7,
  input  logic [7:0] ICW1,
  input  logic [7:0] ICW2,
  input  logic [7:0] ICW4,
  input  logic [7:0] OCW1,
  input  logic       intaStrobe,
  input  logic       eoiStrobe,
  output logic       INT,
  output logic [7:0] vectorOut,
  output logic       vectorValid,
  output logic [7:0] IRR,
  output logic [7:0] ISR
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    ACK2
  } seqState_t;

  seqState_t  state;
  logic [7:0] irPrev;
  logic [2:0] level;
  logic       spurious;

  logic [3:0] hiIsr;
  logic [7:0] higherMask;
  logic [7:0] eligible;
  logic       anyEligible;
  logic [2:0] ackLevel;
  logic       firstAck;
  logic       secondAck;
  logic [7:0] eoiMask;
  logic [7:0] irrNext;
  logic [7:0] isrNext;

  always_comb begin
    hiIsr = 4'd8;
    for (int unsigned i = 0; i < 8; i++) begin
      if (ISR[i] && hiIsr == 4'd8) hiIsr = 4'(i);
    end

    higherMask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      higherMask[i] = (4'(i) < hiIsr);
    end

    eligible    = IRR & ~OCW1 & higherMask;
    anyEligible = |eligible;

    ackLevel = 3'd7;
    for (int unsigned i = 8; i > 0; i--) begin
      if (eligible[i-1]) ackLevel = 3'(i-1);
    end

    firstAck  = (state == PEND) && intaStrobe;
    secondAck = (state == ACK2) && intaStrobe;

    eoiMask = '0;
    if (eoiStrobe && hiIsr != 4'd8) eoiMask[hiIsr[2:0]] = 1'b1;

    irrNext = ICW1[3] ? IR0_to_IR7 : (IRR | (IR0_to_IR7 & ~irPrev));
    if (firstAck && anyEligible) irrNext[ackLevel] = 1'b0;

    // EOI retires the pre-update highest bit before the new level is entered
    isrNext = ISR & ~eoiMask;
    if (firstAck && anyEligible) isrNext[ackLevel] = 1'b1;
    if (secondAck && ICW4[1] && !spurious) isrNext[level] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      irPrev      <= '0;
      level       <= '0;
      spurious    <= 1'b0;
      INT         <= 1'b0;
      vectorOut   <= '0;
      vectorValid <= 1'b0;
      IRR         <= '0;
      ISR         <= '0;
    end else begin
      irPrev      <= IR0_to_IR7;
      IRR         <= irrNext;
      ISR         <= isrNext;
      vectorValid <= 1'b0;
      case (state)
        IDLE: begin
          INT <= 1'b0;
          if (anyEligible) begin
            state <= PEND;
            INT   <= 1'b1;
          end
        end
        PEND: begin
          INT <= 1'b1;
          if (intaStrobe) begin
            level    <= ackLevel;
            spurious <= !anyEligible;
            INT      <= 1'b0;
            state    <= ACK2;
          end
        end
        ACK2: begin
          INT <= 1'b0;
          if (intaStrobe) begin
            vectorOut   <= {ICW2[7:3], level};
            vectorValid <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          INT   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_interrupt_sequencer.sv
// Directed bench for pic_interrupt_sequencer: edge/level requests, nesting,
// masking, spurious acknowledge, AEOI and asynchronous reset.
module tb_pic_interrupt_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] IR0_to_IR7;
  logic [7:0] ICW1;
  logic [7:0] ICW2;
  logic [7:0] ICW4;
  logic [7:0] OCW1;
  logic       intaStrobe;
  logic       eoiStrobe;
  logic       INT;
  logic [7:0] vectorOut;
  logic       vectorValid;
  logic [7:0] IRR;
  logic [7:0] ISR;

  int unsigned checks = 0;
  int unsigned errors = 0;

  pic_interrupt_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .IR0_to_IR7 (IR0_to_IR7),
    .ICW1       (ICW1),
    .ICW2       (ICW2),
    .ICW4       (ICW4),
    .OCW1       (OCW1),
    .intaStrobe (intaStrobe),
    .eoiStrobe  (eoiStrobe),
    .INT        (INT),
    .vectorOut  (vectorOut),
    .vectorValid(vectorValid),
    .IRR        (IRR),
    .ISR        (ISR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic inta();
    intaStrobe = 1'b1;
    step(1);
    intaStrobe = 1'b0;
  endtask

  task automatic eoi();
    eoiStrobe = 1'b1;
    step(1);
    eoiStrobe = 1'b0;
  endtask

  task automatic fullAck();
    inta();
    step(1);
    inta();
  endtask

  initial begin
    reset = 1'b1; IR0_to_IR7 = '0; ICW1 = '0; ICW2 = 8'h40; ICW4 = '0;
    OCW1 = '0; intaStrobe = 1'b0; eoiStrobe = 1'b0;
    step(2);
    chk("rst_INT", {7'd0, INT}, 8'h00);
    chk("rst_vec", vectorOut, 8'h00);
    chk("rst_vv", {7'd0, vectorValid}, 8'h00);
    chk("rst_IRR", IRR, 8'h00);
    chk("rst_ISR", ISR, 8'h00);
    reset = 1'b0;

    // basic edge-mode acknowledge
    IR0_to_IR7 = 8'h08;
    step(1);
    chk("b_IRR1", IRR, 8'h08);
    chk("b_INT1", {7'd0, INT}, 8'h00);
    step(1);
    chk("b_INT2", {7'd0, INT}, 8'h01);
    inta();
    chk("b_INTack", {7'd0, INT}, 8'h00);
    chk("b_ISR", ISR, 8'h08);
    chk("b_IRR", IRR, 8'h00);
    step(1);
    chk("b_vv0", {7'd0, vectorValid}, 8'h00);
    inta();
    chk("b_vec", vectorOut, 8'h43);
    chk("b_vv", {7'd0, vectorValid}, 8'h01);
    step(1);
    chk("b_vvdrop", {7'd0, vectorValid}, 8'h00);
    chk("b_vechold", vectorOut, 8'h43);
    IR0_to_IR7 = '0;
    eoi();
    chk("b_eoi", ISR, 8'h00);

    // nesting: IR5 in service, then IR6 and IR2 together
    IR0_to_IR7 = 8'h20;
    step(2);
    fullAck();
    chk("n_ISR5", ISR, 8'h20);
    chk("n_vec5", vectorOut, 8'h45);
    IR0_to_IR7 = 8'h44;
    step(1);
    chk("n_IRR", IRR, 8'h44);
    step(1);
    chk("n_INT", {7'd0, INT}, 8'h01);
    fullAck();
    chk("n_vec2", vectorOut, 8'h42);
    chk("n_ISR24", ISR, 8'h24);
    chk("n_IRR40", IRR, 8'h40);
    IR0_to_IR7 = '0;
    step(2);
    chk("n_noINT6a", {7'd0, INT}, 8'h00);
    eoi();
    chk("n_eoi1", ISR, 8'h20);
    step(3);
    chk("n_noINT6b", {7'd0, INT}, 8'h00);
    eoi();
    chk("n_eoi2", ISR, 8'h00);
    chk("n_INTlow", {7'd0, INT}, 8'h00);
    step(1);
    chk("n_INT6", {7'd0, INT}, 8'h01);
    fullAck();
    chk("n_vec6", vectorOut, 8'h46);
    chk("n_ISR6", ISR, 8'h40);
    eoi();
    chk("n_eoi3", ISR, 8'h00);
    eoi();
    chk("n_eoiNop", ISR, 8'h00);

    // masking
    OCW1 = 8'h08;
    IR0_to_IR7 = 8'h08;
    step(1);
    chk("m_IRR", IRR, 8'h08);
    for (int unsigned i = 0; i < 20; i++) begin
      step(1);
      chk("m_INTmasked", {7'd0, INT}, 8'h00);
    end
    OCW1 = 8'h00;
    step(1);
    chk("m_INTunmask", {7'd0, INT}, 8'h01);
    fullAck();
    chk("m_vec", vectorOut, 8'h43);
    IR0_to_IR7 = '0;
    eoi();
    chk("m_eoi", ISR, 8'h00);

    // spurious acknowledge in level mode
    ICW1 = 8'h08;
    IR0_to_IR7 = 8'h10;
    step(1);
    chk("s_IRR", IRR, 8'h10);
    step(1);
    chk("s_INT", {7'd0, INT}, 8'h01);
    IR0_to_IR7 = '0;
    step(1);
    chk("s_IRRdrop", IRR, 8'h00);
    chk("s_INThold", {7'd0, INT}, 8'h01);
    inta();
    chk("s_INTack", {7'd0, INT}, 8'h00);
    chk("s_ISR1", ISR, 8'h00);
    step(1);
    inta();
    chk("s_vec", vectorOut, 8'h47);
    chk("s_vv", {7'd0, vectorValid}, 8'h01);
    chk("s_ISR2", ISR, 8'h00);
    ICW1 = 8'h00;
    step(1);

    // automatic EOI
    ICW4 = 8'h02;
    IR0_to_IR7 = 8'h02;
    step(2);
    chk("a_INT", {7'd0, INT}, 8'h01);
    inta();
    chk("a_ISRmid", ISR, 8'h02);
    step(1);
    inta();
    chk("a_ISRend", ISR, 8'h00);
    chk("a_vec", vectorOut, 8'h41);
    IR0_to_IR7 = '0;
    ICW4 = 8'h00;
    step(1);

    // asynchronous reset in ACK2
    IR0_to_IR7 = 8'h08;
    step(2);
    inta();
    chk("r_ISRpre", ISR, 8'h08);
    IR0_to_IR7 = '0;
    #2 reset = 1'b1;
    #1;
    chk("r_INT", {7'd0, INT}, 8'h00);
    chk("r_vec", vectorOut, 8'h00);
    chk("r_vv", {7'd0, vectorValid}, 8'h00);
    chk("r_IRR", IRR, 8'h00);
    chk("r_ISR", ISR, 8'h00);
    step(1);
    reset = 1'b0;
    inta();
    chk("r_noVV", {7'd0, vectorValid}, 8'h00);
    chk("r_ISRpost", ISR, 8'h00);
    chk("r_INTpost", {7'd0, INT}, 8'h00);

    // IR already high when reset releases counts as an edge
    reset = 1'b1;
    IR0_to_IR7 = 8'h01;
    step(1);
    reset = 1'b0;
    step(1);
    chk("e_IRR", IRR, 8'h01);
    step(1);
    chk("e_INT", {7'd0, INT}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
